cordic_range_reduce: RTL and testbench

Upstream stage of the CORDIC trigonometry accelerator. It accepts the IEEE-754 float32 angle written by the host and reduces |theta| modulo pi/2 by iterative shift-and-subtract. It outputs a Q2.30 fixed-point residual angle in [0, pi/2) plus a 2-bit quadrant, which the CORDIC core consumes and uses to fold signs/swap sin-cos. NaN, Inf and out-of-range inputs are flagged instead of reduced.

---
 rtl/cordic_pkg.sv | 36 +++
 rtl/cordic_range_reduce_fp32_unpack.sv | 30 +++
 rtl/cordic_range_reduce.sv | 166 ++++++++++++++++
 tb/tb_cordic_range_reduce.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC trigonometry accelerator: constants,
// float32 field layout and the range-reduction state encoding.
package cordic_pkg;

    localparam int unsigned FP_W           = 32;
    localparam int unsigned FP_EXP_W       = 8;
    localparam int unsigned FP_MAN_W       = 23;
    localparam int unsigned FP_BIAS        = 127;
    localparam int unsigned FP_EXP_SPECIAL = 255;
    localparam int unsigned FP_UEXP_W      = 10;
    localparam int unsigned Q_W            = 32;

    // pi/2 in unsigned Q2.30, truncated
    localparam logic [Q_W-1:0] PI_2_Q30 = 32'h6487ED51;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_SHIFT,
        ST_FINISH
    } rr_state_e;

    typedef enum logic [1:0] {
        FP_NORMAL,
        FP_ZERO,
        FP_INVALID
    } fp_class_e;

    typedef struct packed {
        logic                   sign;
        logic [FP_UEXP_W-1:0]   exp;    // unbiased exponent, two's complement
        logic [FP_MAN_W:0]      mant;   // mantissa with hidden one
        fp_class_e              cls;
    } fp32_fields_t;

endpackage

// File: rtl/cordic_range_reduce_fp32_unpack.sv
// Combinational float32 classifier: splits sign/exponent/mantissa and flags
// zero/denormal and NaN/Inf/too-large inputs.
module fp32_unpack
    import cordic_pkg::*;
#(
    parameter int unsigned MAX_EXP = 23
) (
    input  logic [FP_W-1:0] value,
    output fp32_fields_t    fields_c
);

    logic [FP_EXP_W-1:0]         exp_raw;
    logic signed [FP_UEXP_W-1:0] exp_unb;

    always_comb begin
        exp_raw         = value[FP_W-2:FP_MAN_W];
        exp_unb         = $signed({2'b00, exp_raw}) - $signed(FP_UEXP_W'(FP_BIAS));
        fields_c.sign   = value[FP_W-1];
        fields_c.exp    = exp_unb;
        fields_c.mant   = {1'b1, value[FP_MAN_W-1:0]};
        if (exp_raw == FP_EXP_W'(FP_EXP_SPECIAL) || exp_unb > $signed(FP_UEXP_W'(MAX_EXP))) begin
            fields_c.cls = FP_INVALID;
        end else if (exp_raw == '0) begin
            fields_c.cls = FP_ZERO;
        end else begin
            fields_c.cls = FP_NORMAL;
        end
    end

endmodule

// File: rtl/cordic_range_reduce.sv
// Reduces |theta| (float32) modulo pi/2 by shift-and-subtract, producing a
// Q2.30 residual and a 2-bit quadrant for the CORDIC core.
module cordic_range_reduce
    import cordic_pkg::*;
#(
    parameter int unsigned MAX_EXP = 23
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [FP_W-1:0] theta,
    output logic            busy,
    output logic            done,
    output logic [Q_W-1:0]  angle,
    output logic [1:0]      quadrant,
    output logic            invalid
);

    localparam int unsigned K_W = $clog2(MAX_EXP + 1);
    localparam int unsigned T_W = Q_W + 1;

    rr_state_e        state_q, state_d;
    logic [FP_W-1:0]  theta_q, theta_d;
    logic [T_W-1:0]   r_q, r_d;
    logic [1:0]       q_q, q_d;
    logic [K_W-1:0]   k_q, k_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [Q_W-1:0]   angle_q, angle_d;
    logic [1:0]       quadrant_q, quadrant_d;
    logic             invalid_q, invalid_d;

    fp32_fields_t                fields;
    logic signed [FP_UEXP_W-1:0] e_s;
    logic [FP_UEXP_W-1:0]        neg_shift;
    logic [Q_W-1:0]              r_init;
    logic [T_W-1:0]              sub_a;
    logic [T_W-1:0]              sub_diff;
    logic                        sub_borrow;
    logic [T_W-1:0]              r_step;

    fp32_unpack #(.MAX_EXP(MAX_EXP)) u_unpack (
        .value    (theta_q),
        .fields_c (fields)
    );

    // Initial residual: mantissa as a [1,2) value, scaled down for e < 0
    always_comb begin
        e_s       = fields.exp;
        neg_shift = FP_UEXP_W'(-e_s);
        r_init    = {1'b0, fields.mant, 7'b0};
        if (e_s < 0) begin
            r_init = (neg_shift >= FP_UEXP_W'(Q_W)) ? '0 : (r_init >> neg_shift);
        end
    end

    // The one shared subtractor: compare-and-subtract P in UNPACK and SHIFT
    always_comb begin
        sub_a = (state_q == ST_SHIFT) ? (r_q << 1) : {1'b0, r_init};
        {sub_borrow, sub_diff} = {1'b0, sub_a} - {2'b00, PI_2_Q30};
        r_step = sub_borrow ? sub_a : sub_diff;
    end

    always_comb begin
        state_d    = state_q;
        theta_d    = theta_q;
        r_d        = r_q;
        q_d        = q_q;
        k_d        = k_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        angle_d    = angle_q;
        quadrant_d = quadrant_q;
        invalid_d  = invalid_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    theta_d = theta;
                    busy_d  = 1'b1;
                    state_d = ST_UNPACK;
                end
            end
            ST_UNPACK: begin
                if (fields.cls == FP_NORMAL) begin
                    r_d     = r_step;
                    q_d     = {1'b0, ~sub_borrow};
                    k_d     = (e_s > 0) ? K_W'(e_s) : '0;
                    state_d = (e_s > 0) ? ST_SHIFT : ST_FINISH;
                end else begin
                    r_d     = '0;
                    q_d     = '0;
                    k_d     = '0;
                    state_d = ST_FINISH;
                end
            end
            ST_SHIFT: begin
                r_d = r_step;
                q_d = {q_q[0], ~sub_borrow};
                k_d = k_q - K_W'(1);
                if (k_q == K_W'(1)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (fields.cls == FP_INVALID) begin
                    angle_d    = '0;
                    quadrant_d = '0;
                    invalid_d  = 1'b1;
                end else begin
                    invalid_d = 1'b0;
                    // Negative angles fold to P-r with mirrored quadrant
                    if (fields.sign && (r_q != '0)) begin
                        angle_d    = Q_W'({1'b0, PI_2_Q30} - r_q);
                        quadrant_d = 2'd3 - q_q;
                    end else if (fields.sign) begin
                        angle_d    = Q_W'(r_q);
                        quadrant_d = 2'd0 - q_q;
                    end else begin
                        angle_d    = Q_W'(r_q);
                        quadrant_d = q_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            theta_q    <= '0;
            r_q        <= '0;
            q_q        <= '0;
            k_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            angle_q    <= '0;
            quadrant_q <= '0;
            invalid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            theta_q    <= theta_d;
            r_q        <= r_d;
            q_q        <= q_d;
            k_q        <= k_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            angle_q    <= angle_d;
            quadrant_q <= quadrant_d;
            invalid_q  <= invalid_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign angle    = angle_q;
    assign quadrant = quadrant_q;
    assign invalid  = invalid_q;

endmodule

// File: tb/tb_cordic_range_reduce.sv
// Directed bench for cordic_range_reduce: a long-division model of the
// reduction plus literal expectations, checked every cycle at the negedge.
module tb_cordic_range_reduce;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] theta;
    logic        busy;
    logic        done;
    logic [31:0] angle;
    logic [1:0]  quadrant;
    logic        invalid;

    typedef struct {
        logic [31:0] angle;
        logic [1:0]  quad;
        logic        inv;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t last;
    exp_t cur;
    int   n_cmp;
    int   n_err;

    cordic_range_reduce #(.MAX_EXP(23)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .theta    (theta),
        .busy     (busy),
        .done     (done),
        .angle    (angle),
        .quadrant (quadrant),
        .invalid  (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reduction as one long division: |theta| scaled to Q2.30 is X, result is X mod P, X div P
    function automatic exp_t model(input logic [31:0] th);
        exp_t o;
        int ee;
        longint unsigned r0, x, qt, rem;
        longint unsigned p;
        logic [7:0] ex;
        p = 64'h6487ED51;
        ex = th[30:23];
        o.angle = '0;
        o.quad  = '0;
        o.inv   = 1'b0;
        o.lat   = 2;
        ee = int'(ex) - 127;
        if (ex == 8'hFF || ee > 23) begin
            o.inv = 1'b1;
        end else if (ex != 8'h00) begin
            r0 = {40'd0, 1'b1, th[22:0]} << 7;
            if (ee < 0) begin
                x = (-ee >= 32) ? 64'd0 : (r0 >> (-ee));
            end else begin
                x = r0 << ee;
                o.lat = 2 + ee;
            end
            qt  = x / p;
            rem = x % p;
            if (th[31] && rem != 0) begin
                o.angle = 32'(p - rem);
                o.quad  = 2'(64'd3 - qt);
            end else if (th[31]) begin
                o.angle = 32'(rem);
                o.quad  = 2'(64'd0 - qt);
            end else begin
                o.angle = 32'(rem);
                o.quad  = 2'(qt);
            end
        end
        return o;
    endfunction

    // Every cycle: outputs either match the popped expectation on done or hold
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            last = '{32'd0, 2'd0, 1'b0, 0};
            chk("reset_busy", 32'(busy), 32'd0);
            chk("reset_done", 32'(done), 32'd0);
        end else if (done) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 32'(done), 32'd0);
            end else begin
                cur  = exp_q.pop_front();
                last = cur;
            end
        end
        chk("angle", angle, last.angle);
        chk("quadrant", 32'(quadrant), 32'(last.quad));
        chk("invalid", 32'(invalid), 32'(last.inv));
    end

    task automatic run(input logic [31:0] th, input bit lit, input logic [31:0] la,
                       input logic [1:0] lq, input logic li, input bit poke);
        exp_t e;
        int cycles;
        e = model(th);
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        theta = th;
        @(posedge clk);
        #1;
        theta  = $urandom;
        cycles = 0;
        start  = poke;
        chk("busy_after_start", 32'(busy), 32'd1);
        while (!done && cycles < 40) begin
            @(posedge clk);
            cycles++;
            #1;
            start = poke && (cycles < 2);
        end
        start = 1'b0;
        chk("latency", 32'(cycles), 32'(e.lat));
        chk("busy_at_done", 32'(busy), 32'd0);
        if (lit) begin
            chk("lit_angle", angle, la);
            chk("lit_quadrant", 32'(quadrant), 32'(lq));
            chk("lit_invalid", 32'(invalid), 32'(li));
        end
    endtask

    task automatic reset_mid_shift();
        @(negedge clk);
        start = 1'b1;
        theta = 32'h447A0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_angle", angle, 32'd0);
        chk("rst_quadrant", 32'(quadrant), 32'd0);
        chk("rst_invalid", 32'(invalid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        last  = '{32'd0, 2'd0, 1'b0, 0};
        rst_n = 1'b0;
        start = 1'b0;
        theta = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run(32'h00000000, 1'b1, 32'h00000000, 2'd0, 1'b0, 1'b0);
        run(32'h3F800000, 1'b1, 32'h40000000, 2'd0, 1'b0, 1'b0);
        run(32'hBF800000, 1'b1, 32'h2487ED51, 2'd3, 1'b0, 1'b0);
        run(32'h40000000, 1'b1, 32'h1B7812AF, 2'd1, 1'b0, 1'b0);
        run(32'h40490FDB, 1'b1, 32'h0000005E, 2'd2, 1'b0, 1'b0);
        run(32'hC0490FDB, 1'b1, 32'h6487ECF3, 2'd1, 1'b0, 1'b0);
        run(32'h7FC00000, 1'b1, 32'h00000000, 2'd0, 1'b1, 1'b0);
        run(32'h3F800000, 1'b1, 32'h40000000, 2'd0, 1'b0, 1'b0);
        run(32'h4B800000, 1'b1, 32'h00000000, 2'd0, 1'b1, 1'b0);
        run(32'hFF800000, 1'b0, '0, '0, 1'b0, 1'b0);
        run(32'h4B7FFFFF, 1'b0, '0, '0, 1'b0, 1'b0);
        run(32'hCB7FFFFF, 1'b0, '0, '0, 1'b0, 1'b0);
        run(32'h447A0000, 1'b0, '0, '0, 1'b0, 1'b0);
        run(32'h3E800000, 1'b0, '0, '0, 1'b0, 1'b0);
        run(32'h33000000, 1'b0, '0, '0, 1'b0, 1'b0);
        run(32'h2F800000, 1'b0, '0, '0, 1'b0, 1'b0);
        run(32'hAF800000, 1'b0, '0, '0, 1'b0, 1'b0);
        run(32'h00000001, 1'b0, '0, '0, 1'b0, 1'b0);
        run(32'h80000000, 1'b0, '0, '0, 1'b0, 1'b0);
        run(32'hC1200000, 1'b0, '0, '0, 1'b0, 1'b0);
        run(32'h40000000, 1'b1, 32'h1B7812AF, 2'd1, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        reset_mid_shift();
        run(32'h3F800000, 1'b1, 32'h40000000, 2'd0, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        chk("pending_results", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
